// File: rtl/sat_cnt_table.sv
// Table of DEPTH saturating branch counters with a registered lookup port and a 2-stage RMW update port.
// Optional macro SAT_CNT_TABLE_BYPASS_EN: a lookup that hits the in-progress U2 write sees the new value.
module sat_cnt_table #(
    parameter int                CNT_W    = 2,
    parameter int                DEPTH    = 512,
    parameter int                IDX_W    = $clog2(DEPTH),
    parameter logic [CNT_W-1:0]  INIT_VAL = CNT_W'((1 << (CNT_W - 1)) - 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             init_busy_o,
    input  logic             pred_valid_i,
    input  logic [IDX_W-1:0] pred_idx_i,
    output logic             pred_vld_o,
    output logic [CNT_W-1:0] pred_cnt_o,
    output logic             pred_taken_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    logic [IDX_W-1:0] walk_q;
    logic             init_busy_q;
    logic             upd_ready_q;

    logic [CNT_W-1:0] mem_q [DEPTH];

    logic             pred_vld_q, pred_vld_d;
    logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d;

    // U2 stage registers: the update accepted in the previous cycle
    logic             u2_vld_q, u2_vld_d;
    logic [IDX_W-1:0] u2_idx_q, u2_idx_d;
    logic             u2_taken_q, u2_taken_d;
    logic [CNT_W-1:0] u2_cnt_q, u2_cnt_d;

    logic [CNT_W-1:0] u2_new;
    logic [CNT_W-1:0] pred_rd;
    logic             upd_fire;

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] cnt,
                                                   input logic             taken);
        if (taken) begin
            return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
        return (cnt == '0) ? cnt : cnt - CNT_W'(1);
    endfunction

    // Init walk FSM; status outputs are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            walk_q      <= '0;
            init_busy_q <= 1'b1;
            upd_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    walk_q <= walk_q + IDX_W'(1);
                    if (walk_q == IDX_W'(DEPTH - 1)) begin
                        state_q     <= ST_RUN;
                        init_busy_q <= 1'b0;
                        upd_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    always_comb begin
        u2_new   = sat_next(u2_cnt_q, u2_taken_q);
        upd_fire = upd_valid_i && upd_ready_q;

        u2_vld_d   = upd_fire;
        u2_idx_d   = upd_idx_i;
        u2_taken_d = upd_taken_i;
        // Back-to-back updates to one entry must see the value being written this cycle.
        u2_cnt_d   = (u2_vld_q && (u2_idx_q == upd_idx_i)) ? u2_new : mem_q[upd_idx_i];

        pred_rd = mem_q[pred_idx_i];
`ifdef SAT_CNT_TABLE_BYPASS_EN
        if (u2_vld_q && (u2_idx_q == pred_idx_i)) begin
            pred_rd = u2_new;
        end
`endif
        pred_vld_d = pred_valid_i && (state_q == ST_RUN);
        pred_cnt_d = pred_vld_d ? pred_rd : pred_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_vld_q <= 1'b0;
            pred_cnt_q <= '0;
            u2_vld_q   <= 1'b0;
            u2_idx_q   <= '0;
            u2_taken_q <= 1'b0;
            u2_cnt_q   <= '0;
        end else begin
            pred_vld_q <= pred_vld_d;
            pred_cnt_q <= pred_cnt_d;
            u2_vld_q   <= u2_vld_d;
            u2_idx_q   <= u2_idx_d;
            u2_taken_q <= u2_taken_d;
            u2_cnt_q   <= u2_cnt_d;
        end
    end

    // NOTE: the array has no reset branch; the init walk fills it, and a reset cycle only blocks writes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == ST_INIT) begin
                mem_q[walk_q] <= INIT_VAL;
            end else if (u2_vld_q) begin
                mem_q[u2_idx_q] <= u2_new;
            end
        end
    end

    assign init_busy_o  = init_busy_q;
    assign upd_ready_o  = upd_ready_q;
    assign pred_vld_o   = pred_vld_q;
    assign pred_cnt_o   = pred_cnt_q;
    assign pred_taken_o = pred_cnt_q[CNT_W-1];

endmodule
